// File: rtl/wb_arbiter.sv
// Two-master (D = load/store, F = fetch) to one-slave Wishbone B.4 pipelined arbiter, 16-bit data.
// Optional macro WBARB_ROUND_ROBIN_EN: alternate simultaneous grants; otherwise D has fixed priority.
module wb_arbiter #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] d_adr_i,
  input  logic [15:0] d_dat_i,
  input  logic        d_we_i,
  input  logic [1:0]  d_sel_i,
  input  logic        d_stb_i,
  input  logic        d_cyc_i,
  output logic        d_ack_o,
  output logic [15:0] d_dat_o,
  output logic        d_stall_o,
  input  logic [63:0] f_adr_i,
  input  logic [15:0] f_dat_i,
  input  logic        f_we_i,
  input  logic [1:0]  f_sel_i,
  input  logic        f_stb_i,
  input  logic        f_cyc_i,
  output logic        f_ack_o,
  output logic [15:0] f_dat_o,
  output logic        f_stall_o,
  output logic [63:0] wbmadr_o,
  output logic [15:0] wbmdat_o,
  output logic        wbmwe_o,
  output logic [1:0]  wbmsel_o,
  output logic        wbmstb_o,
  output logic        wbmcyc_o,
  input  logic        wbmack_i,
  input  logic [15:0] wbmdat_i,
  input  logic        wbmstall_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    OWN_D = 3'b010,
    OWN_F = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_nz;
  logic             own_stall;
  logic             owned;
  logic             beat_acc;
  logic             ack_fwd;
  logic             last_ack;

`ifdef WBARB_ROUND_ROBIN_EN
  logic             last_f_q, last_f_d;
`endif

  assign cnt_nz    = (cnt_q != '0);
  assign owned     = (state_q != IDLE);
  assign own_stall = wbmstall_i | (cnt_q == CNT_MAX);
  assign beat_acc  = owned & wbmstb_o & ~own_stall;
  // Acks with nothing outstanding are stray and neither counted nor forwarded.
  assign ack_fwd   = owned & wbmack_i & cnt_nz;
  assign last_ack  = ack_fwd & (cnt_q == CNT_ONE) & ~beat_acc;

  always_comb begin
    wbmadr_o  = '0;
    wbmdat_o  = '0;
    wbmwe_o   = 1'b0;
    wbmsel_o  = '0;
    wbmstb_o  = 1'b0;
    wbmcyc_o  = 1'b0;
    d_ack_o   = 1'b0;
    d_dat_o   = '0;
    d_stall_o = 1'b1;
    f_ack_o   = 1'b0;
    f_dat_o   = '0;
    f_stall_o = 1'b1;
    unique case (state_q)
      OWN_D: begin
        wbmadr_o  = d_adr_i;
        wbmdat_o  = d_dat_i;
        wbmwe_o   = d_we_i & d_stb_i;
        wbmsel_o  = d_sel_i & {2{d_stb_i}};
        wbmstb_o  = d_stb_i;
        wbmcyc_o  = d_cyc_i | cnt_nz;
        d_ack_o   = ack_fwd;
        d_dat_o   = wbmdat_i;
        d_stall_o = own_stall;
      end
      OWN_F: begin
        wbmadr_o  = f_adr_i;
        wbmdat_o  = f_dat_i;
        wbmwe_o   = f_we_i & f_stb_i;
        wbmsel_o  = f_sel_i & {2{f_stb_i}};
        wbmstb_o  = f_stb_i;
        wbmcyc_o  = f_cyc_i | cnt_nz;
        f_ack_o   = ack_fwd;
        f_dat_o   = wbmdat_i;
        f_stall_o = own_stall;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef WBARB_ROUND_ROBIN_EN
    last_f_d = last_f_q;
`endif
    if (beat_acc && !ack_fwd) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!beat_acc && ack_fwd) begin
      cnt_d = cnt_q - CNT_ONE;
    end
    unique case (state_q)
      IDLE: begin
        if (d_cyc_i && f_cyc_i) begin
`ifdef WBARB_ROUND_ROBIN_EN
          state_d = last_f_q ? OWN_D : OWN_F;
`else
          state_d = OWN_D;
`endif
        end else if (d_cyc_i) begin
          state_d = OWN_D;
        end else if (f_cyc_i) begin
          state_d = OWN_F;
        end
`ifdef WBARB_ROUND_ROBIN_EN
        if (state_d == OWN_D) last_f_d = 1'b0;
        if (state_d == OWN_F) last_f_d = 1'b1;
`endif
      end
      // Release only once the last outstanding beat is acked; a dropped cyc waits for the drain.
      OWN_D: if ((!d_cyc_i && !cnt_nz) || last_ack) state_d = IDLE;
      OWN_F: if ((!f_cyc_i && !cnt_nz) || last_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef WBARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i) last_f_q <= 1'b1;
    else          last_f_q <= last_f_d;
  end
`endif

endmodule
